// File: rtl/game_pkg.sv
// Shared types and constants for the game sequencer and the draw stage.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COUNTDOWN = 3'd1,
        PLAY      = 3'd2,
        CAUGHT    = 3'd3,
        TIMEOUT   = 3'd4,
        GAME_OVER = 3'd5
    } game_state_t;

    // Sprite sizes, also used by draw_tom and the jerry drawer
    localparam int TOM_WIDTH    = 64;
    localparam int TOM_HEIGHT   = 64;
    localparam int JERRY_WIDTH  = 32;
    localparam int JERRY_HEIGHT = 32;

    localparam int DEF_ROUND_FRAMES = 1800;
    localparam int DEF_START_DELAY  = 60;
    localparam int DEF_HOLD_FRAMES  = 120;
    localparam int DEF_WIN_SCORE    = 3;

    // Strict 1-D overlap of [a, a+a_len) and [b, b+b_len); 11-bit sums never wrap,
    // and spans that only touch do not overlap.
    function automatic logic span_overlap(
        input logic [9:0]  a_pos,
        input logic [10:0] a_len,
        input logic [9:0]  b_pos,
        input logic [10:0] b_len
    );
        logic [10:0] a_ext;
        logic [10:0] b_ext;
        a_ext = {1'b0, a_pos};
        b_ext = {1'b0, b_pos};
        return (a_ext < (b_ext + b_len)) && (b_ext < (a_ext + a_len));
    endfunction

endpackage

// File: rtl/edge_det.sv
// Registered rising-edge detector. The input must be seen low at least once after
// reset before an edge can be reported, so a level already high at reset release
// does not produce a pulse.
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic pulse_o
);

    logic sig_q;
    logic armed_q;
    logic pulse_q;

    // Delay register, arm flag and one-cycle edge pulse
    always_ff @(posedge clk) begin
        if (!rst) begin
            sig_q   <= 1'b0;
            armed_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sig_q   <= sig_i;
            armed_q <= armed_q | ~sig_i;
            pulse_q <= sig_i & ~sig_q & armed_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/game_ctrl.sv
// Round/state sequencer for the Tom & Jerry game: gates the move controllers,
// counts round time in frames, detects catches and keeps both scores.
//
//  state     | meaning
//  ----------+---------------------------------------------------------
//  IDLE      | waiting for start button
//  COUNTDOWN | frozen pre-round delay, START_DELAY frames
//  PLAY      | characters move; catch / round timer checked per frame
//  CAUGHT    | Tom won the round, result held HOLD_FRAMES frames
//  TIMEOUT   | Jerry survived the round, result held HOLD_FRAMES frames
//  GAME_OVER | a player reached WIN_SCORE; waits for start to go IDLE
module game_ctrl
    import game_pkg::*;
#(
    parameter int TOM_W        = TOM_WIDTH,
    parameter int TOM_H        = TOM_HEIGHT,
    parameter int JERRY_W      = JERRY_WIDTH,
    parameter int JERRY_H      = JERRY_HEIGHT,
    parameter int ROUND_FRAMES = DEF_ROUND_FRAMES,
    parameter int START_DELAY  = DEF_START_DELAY,
    parameter int HOLD_FRAMES  = DEF_HOLD_FRAMES,
    parameter int WIN_SCORE    = DEF_WIN_SCORE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vsync,
    input  logic        start_b,
    input  logic [9:0]  tom_x,
    input  logic [9:0]  tom_y,
    input  logic [9:0]  jerry_x,
    input  logic [9:0]  jerry_y,
    output logic        move_en,
    output logic        pos_reset,
    output logic [2:0]  state_o,
    output logic [10:0] frames_left,
    output logic [7:0]  score_tom,
    output logic [7:0]  score_jerry
);

    localparam logic [10:0] ROUND_LEN  = 11'(ROUND_FRAMES);
    localparam logic [10:0] START_LAST = 11'(START_DELAY - 1);
    localparam logic [10:0] HOLD_LAST  = 11'(HOLD_FRAMES - 1);
    localparam logic [7:0]  WIN_PTS    = 8'(WIN_SCORE);

    logic frame_tick;
    logic start_pe;
    logic catch_w;

    game_state_t state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [10:0] frames_left_q, frames_left_d;
    logic [7:0]  score_tom_q, score_tom_d;
    logic [7:0]  score_jerry_q, score_jerry_d;
    logic        move_en_q, move_en_d;
    logic        pos_reset_q, pos_reset_d;

    edge_det u_vsync_edge (
        .clk     (clk),
        .rst     (rst),
        .sig_i   (vsync),
        .pulse_o (frame_tick)
    );

    edge_det u_start_edge (
        .clk     (clk),
        .rst     (rst),
        .sig_i   (start_b),
        .pulse_o (start_pe)
    );

    // Bounding boxes overlap strictly on both axes
    assign catch_w = span_overlap(tom_x, 11'(TOM_W), jerry_x, 11'(JERRY_W)) &&
                     span_overlap(tom_y, 11'(TOM_H), jerry_y, 11'(JERRY_H));

    // Next state, frame counter, round timer, scores and output strobes
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        frames_left_d = frames_left_q;
        score_tom_d   = score_tom_q;
        score_jerry_d = score_jerry_q;
        pos_reset_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_pe) begin
                    state_d       = COUNTDOWN;
                    pos_reset_d   = 1'b1;
                    score_tom_d   = 8'd0;
                    score_jerry_d = 8'd0;
                end
            end
            COUNTDOWN: begin
                if (frame_tick) begin
                    if (cnt_q == START_LAST) begin
                        state_d       = PLAY;
                        frames_left_d = ROUND_LEN;
                    end else begin
                        cnt_d = cnt_q + 11'd1;
                    end
                end
            end
            PLAY: begin
                if (frame_tick) begin
                    // A catch on the last frame still goes to Tom
                    if (catch_w) begin
                        state_d     = CAUGHT;
                        score_tom_d = score_tom_q + 8'd1;
                    end else if (frames_left_q == 11'd1) begin
                        state_d       = TIMEOUT;
                        frames_left_d = 11'd0;
                        score_jerry_d = score_jerry_q + 8'd1;
                    end else begin
                        frames_left_d = frames_left_q - 11'd1;
                    end
                end
            end
            CAUGHT, TIMEOUT: begin
                if (frame_tick) begin
                    if (cnt_q == HOLD_LAST) begin
                        if ((score_tom_q == WIN_PTS) || (score_jerry_q == WIN_PTS)) begin
                            state_d = GAME_OVER;
                        end else begin
                            state_d     = COUNTDOWN;
                            pos_reset_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 11'd1;
                    end
                end
            end
            GAME_OVER: begin
                if (start_pe) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Shared counter restarts on every state change
        if (state_d != state_q) begin
            cnt_d = 11'd0;
        end

        move_en_d = (state_d == PLAY);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= 11'd0;
            frames_left_q <= ROUND_LEN;
            score_tom_q   <= 8'd0;
            score_jerry_q <= 8'd0;
            move_en_q     <= 1'b0;
            pos_reset_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            frames_left_q <= frames_left_d;
            score_tom_q   <= score_tom_d;
            score_jerry_q <= score_jerry_d;
            move_en_q     <= move_en_d;
            pos_reset_q   <= pos_reset_d;
        end
    end

    assign move_en     = move_en_q;
    assign pos_reset   = pos_reset_q;
    assign state_o     = state_q;
    assign frames_left = frames_left_q;
    assign score_tom   = score_tom_q;
    assign score_jerry = score_jerry_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with default parameters.
module tb_game_ctrl;
    import game_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vsync = 1'b0;
    logic        start_b = 1'b0;
    logic [9:0]  tom_x = 10'd0;
    logic [9:0]  tom_y = 10'd0;
    logic [9:0]  jerry_x = 10'd500;
    logic [9:0]  jerry_y = 10'd400;
    logic        move_en;
    logic        pos_reset;
    logic [2:0]  state_o;
    logic [10:0] frames_left;
    logic [7:0]  score_tom;
    logic [7:0]  score_jerry;

    int n_checks = 0;
    int n_errors = 0;
    int tick_cnt = 0;
    int pr_cnt = 0;
    int cd_entries = 0;
    int mark;
    logic [2:0] prev_state = 3'd0;

    game_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .vsync       (vsync),
        .start_b     (start_b),
        .tom_x       (tom_x),
        .tom_y       (tom_y),
        .jerry_x     (jerry_x),
        .jerry_y     (jerry_y),
        .move_en     (move_en),
        .pos_reset   (pos_reset),
        .state_o     (state_o),
        .frames_left (frames_left),
        .score_tom   (score_tom),
        .score_jerry (score_jerry)
    );

    always #5 clk = ~clk;

    // Event counters sampled on the falling edge
    always @(negedge clk) begin
        if (dut.frame_tick) tick_cnt++;
        if (pos_reset) pr_cnt++;
        if (state_o == COUNTDOWN && prev_state != COUNTDOWN) cd_entries++;
        prev_state = state_o;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) vsync = 1'b1;
            @(negedge clk);
            @(negedge clk) vsync = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic press_start();
        @(negedge clk) start_b = 1'b1;
        repeat (3) @(negedge clk);
        start_b = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic place(input int tx, input int ty, input int jx, input int jy);
        @(negedge clk);
        tom_x   = 10'(tx);
        tom_y   = 10'(ty);
        jerry_x = 10'(jx);
        jerry_y = 10'(jy);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        check("rst_state", int'(state_o), int'(IDLE));
        check("rst_move_en", int'(move_en), 0);
        check("rst_pos_reset", int'(pos_reset), 0);
        check("rst_frames_left", int'(frames_left), 1800);
        check("rst_scores", int'(score_tom) + int'(score_jerry), 0);

        // Held start button over 10 frames: one entry, one pos_reset
        @(negedge clk) start_b = 1'b1;
        repeat (2) @(negedge clk);
        frames(10);
        start_b = 1'b0;
        check("start_cd_entries", cd_entries, 1);
        check("start_pos_reset", pr_cnt, 1);
        check("start_state", int'(state_o), int'(COUNTDOWN));
        frames(49);
        check("cd59_state", int'(state_o), int'(COUNTDOWN));
        check("cd59_move_en", int'(move_en), 0);
        frames(1);
        check("cd60_state", int'(state_o), int'(PLAY));
        check("cd60_move_en", int'(move_en), 1);
        check("cd60_frames_left", int'(frames_left), 1800);

        press_start();
        check("play_ignores_start", int'(state_o), int'(PLAY));

        // Touching edges are not a catch
        place(100, 100, 164, 100);
        frames(1);
        check("touch_right_state", int'(state_o), int'(PLAY));
        check("touch_right_frames", int'(frames_left), 1799);
        place(100, 100, 100, 164);
        frames(1);
        check("touch_below_state", int'(state_o), int'(PLAY));
        place(100, 100, 68, 100);
        frames(1);
        check("touch_left_state", int'(state_o), int'(PLAY));
        check("touch_left_frames", int'(frames_left), 1797);

        place(100, 100, 163, 100);
        frames(1);
        check("catch_state", int'(state_o), int'(CAUGHT));
        check("catch_score_tom", int'(score_tom), 1);
        check("catch_score_jerry", int'(score_jerry), 0);
        check("catch_move_en", int'(move_en), 0);
        check("catch_frames_left", int'(frames_left), 1797);

        place(0, 0, 500, 400);
        frames(119);
        check("hold119_state", int'(state_o), int'(CAUGHT));
        mark = pr_cnt;
        frames(1);
        check("hold120_state", int'(state_o), int'(COUNTDOWN));
        check("hold120_pos_reset", pr_cnt - mark, 1);
        frames(60);
        check("round2_play", int'(state_o), int'(PLAY));

        // Timeout round
        frames(1799);
        check("to_last_state", int'(state_o), int'(PLAY));
        check("to_last_frames", int'(frames_left), 1);
        frames(1);
        check("to_state", int'(state_o), int'(TIMEOUT));
        check("to_frames_left", int'(frames_left), 0);
        check("to_score_jerry", int'(score_jerry), 1);
        check("to_move_en", int'(move_en), 0);
        frames(120);
        check("to_hold_state", int'(state_o), int'(COUNTDOWN));
        frames(60);

        // Catch on the final frame beats the timeout
        frames(1799);
        place(100, 100, 163, 100);
        frames(1);
        check("last_catch_state", int'(state_o), int'(CAUGHT));
        check("last_catch_score_tom", int'(score_tom), 2);
        check("last_catch_score_jerry", int'(score_jerry), 1);
        check("last_catch_frames", int'(frames_left), 1);

        // Third catch ends the game
        place(0, 0, 500, 400);
        frames(120);
        frames(60);
        check("round4_play", int'(state_o), int'(PLAY));
        place(100, 100, 163, 100);
        frames(1);
        check("win_score_tom", int'(score_tom), 3);
        place(0, 0, 500, 400);
        frames(119);
        check("win_hold_state", int'(state_o), int'(CAUGHT));
        frames(1);
        check("gameover_state", int'(state_o), int'(GAME_OVER));
        frames(5);
        check("gameover_stays", int'(state_o), int'(GAME_OVER));
        press_start();
        check("go_idle_state", int'(state_o), int'(IDLE));
        check("go_idle_score_tom", int'(score_tom), 3);
        check("go_idle_score_jerry", int'(score_jerry), 1);
        mark = pr_cnt;
        press_start();
        check("restart_state", int'(state_o), int'(COUNTDOWN));
        check("restart_score_tom", int'(score_tom), 0);
        check("restart_score_jerry", int'(score_jerry), 0);
        check("restart_pos_reset", pr_cnt - mark, 1);

        // Reset in the middle of a round
        frames(60);
        place(100, 100, 163, 100);
        frames(1);
        place(0, 0, 500, 400);
        frames(120);
        frames(60);
        frames(5);
        check("pre_rst_state", int'(state_o), int'(PLAY));
        check("pre_rst_frames", int'(frames_left), 1795);
        do_reset();
        check("midrst_state", int'(state_o), int'(IDLE));
        check("midrst_move_en", int'(move_en), 0);
        check("midrst_score_tom", int'(score_tom), 0);
        check("midrst_frames_left", int'(frames_left), 1800);

        // vsync held high: one tick only
        mark = tick_cnt;
        @(negedge clk) vsync = 1'b1;
        repeat (500) @(negedge clk);
        vsync = 1'b0;
        repeat (3) @(negedge clk);
        check("vsync_held_ticks", tick_cnt - mark, 1);

        // vsync high across reset release: no tick until it falls and rises
        @(negedge clk) vsync = 1'b1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        mark = tick_cnt;
        repeat (20) @(negedge clk);
        check("vsync_rst_no_tick", tick_cnt - mark, 0);
        vsync = 1'b0;
        repeat (3) @(negedge clk);
        vsync = 1'b1;
        repeat (3) @(negedge clk);
        vsync = 1'b0;
        repeat (2) @(negedge clk);
        check("vsync_rst_retick", tick_cnt - mark, 1);
        check("vsync_rst_state", int'(state_o), int'(IDLE));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
